// File: rtl/queue_scheduler.sv
// Queue scheduler: serialises enqueue (from the deserializer) and dequeue
// (toward the consumer) onto a queue that accepts one operation per cycle.
// Every granted operation takes three cycles: IDLE decision, a one-cycle
// strobe, and SETTLE so that len_in can reflect the operation before the
// next decision. Ties are broken round-robin, and dequeues are rate-limited
// by a drain-gap counter.
module queue_scheduler #(
  parameter int DEPTH     = 8,
  parameter int LEN_W     = 4,
  parameter int DRAIN_GAP = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             word_ready_in,
  output logic             word_ack_out,
  output logic             enqueue_out,
  output logic             dequeue_out,
  input  logic [LEN_W-1:0] len_in,
  input  logic             consumer_ready_in,
  output logic             consumer_valid_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             deser_enable_out,
  output logic [7:0]       word_count_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENQ    = 2'd1;
  localparam logic [1:0] ST_DEQ    = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  localparam logic GRANT_DEQ = 1'b0;
  localparam logic GRANT_ENQ = 1'b1;

  // +2 keeps the counter at least one bit wide when DRAIN_GAP is 0.
  localparam int               GAP_W    = $clog2(DRAIN_GAP + 2);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DRAIN_GAP);
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             from_deq_q, from_deq_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       word_count_q, word_count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             deser_en_q, deser_en_d;

  logic has_room;
  logic enq_ok;
  logic deq_ok;

  // Request qualification; any len_in at or above DEPTH counts as full.
  always_comb begin
    has_room = (len_in < DEPTH_L);
    enq_ok   = word_ready_in && has_room;
    deq_ok   = consumer_ready_in && (len_in != '0) && (gap_cnt_q == '0);
  end

  // Next-state, grant, gap and status computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    from_deq_d   = from_deq_q;
    word_count_d = word_count_q;
    gap_cnt_d    = (gap_cnt_q != '0) ? gap_cnt_q - 1'b1 : gap_cnt_q;
    full_d       = !has_room;
    empty_d      = (len_in == '0);
    deser_en_d   = has_room;

    case (state_q)
      ST_IDLE: begin
        if (enq_ok && deq_ok) begin
          state_d = (last_grant_q == GRANT_DEQ) ? ST_ENQ : ST_DEQ;
        end else if (enq_ok) begin
          state_d = ST_ENQ;
        end else if (deq_ok) begin
          state_d = ST_DEQ;
        end
      end
      ST_ENQ: begin
        word_count_d = word_count_q + 8'd1;
        last_grant_d = GRANT_ENQ;
        from_deq_d   = 1'b0;
        state_d      = ST_SETTLE;
      end
      ST_DEQ: begin
        gap_cnt_d    = GAP_LOAD;
        last_grant_d = GRANT_DEQ;
        from_deq_d   = 1'b1;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_DEQ;
      from_deq_q   <= 1'b0;
      gap_cnt_q    <= '0;
      word_count_q <= 8'd0;
      full_q       <= 1'b0;
      empty_q      <= 1'b0;
      deser_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      from_deq_q   <= from_deq_d;
      gap_cnt_q    <= gap_cnt_d;
      word_count_q <= word_count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      deser_en_q   <= deser_en_d;
    end
  end

  // Moore output decode from registered state.
  always_comb begin
    enqueue_out        = (state_q == ST_ENQ);
    word_ack_out       = (state_q == ST_ENQ);
    dequeue_out        = (state_q == ST_DEQ);
    consumer_valid_out = (state_q == ST_SETTLE) && from_deq_q;
    full_out           = full_q;
    empty_out          = empty_q;
    deser_enable_out   = deser_en_q;
    word_count_out     = word_count_q;
  end

endmodule

// File: doc/queue_scheduler.md
Name: queue_scheduler

Overview:
- Sequences the byte queue that sits between the serial deserializer and the downstream consumer.
- Accepts completed words from the deserializer and issues single-cycle enqueue pulses.
- Drains the queue toward a consumer with a ready/valid handshake and a minimum drain gap.
- Arbitrates round-robin between enqueue and dequeue, since the queue performs at most one operation per cycle and gates deserializer input when the queue is full.

Parameters:
DEPTH, 8, queue capacity in words
LEN_W, 4, width of the queue occupancy count (must hold 0..DEPTH)
DRAIN_GAP, 2, minimum idle cycles after a dequeue before the next dequeue (0 = no gap)

Ports:
clock  in  1  system clock, single clock domain
reset  in  1  synchronous, active-low reset (sampled on rising edge of clock; 0 = reset)
word_ready_in  in  1  deserializer holds a complete byte; level, held until word_ack_out
word_ack_out  out  1  one-cycle pulse: word accepted (coincident with enqueue_out)
enqueue_out  out  1  one-cycle enqueue strobe to queue
dequeue_out  out  1  one-cycle dequeue strobe to queue
len_in  in  LEN_W  queue occupancy; updates the cycle after an enqueue/dequeue strobe
consumer_ready_in  in  1  consumer can take a word
consumer_valid_out  out  1  queue data output is valid for the consumer this cycle
full_out  out  1  registered: len_in == DEPTH
empty_out  out  1  registered: len_in == 0
deser_enable_out  out  1  registered: 1 when len_in < DEPTH (deserializer may shift bits)
word_count_out  out  8  count of words enqueued since reset, wraps 255->0

Behaviour:
- Reset: reset == 0 at a rising edge forces state IDLE, gap_cnt=0, last_grant=DEQ, word_count_out=0, and all 1-bit outputs 0 (including deser_enable_out). A reset asserted mid-operation aborts that operation; no pulse completes afterward.
- Outputs are Moore-decoded from registered state; full/empty/deser_enable are registered from len_in every cycle.
- States: IDLE, ENQ, DEQ, SETTLE.
  - enq_ok = word_ready_in && (len_in < DEPTH).
  - deq_ok = consumer_ready_in && (len_in != 0) && (gap_cnt == 0).
- IDLE transitions:
  - Only enq_ok: go to ENQ.
  - Only deq_ok: go to DEQ.
  - Both: grant the type opposite last_grant, so the first tie after reset goes to ENQ.
  - Neither: stay in IDLE.
- ENQ (1 cycle): enqueue_out=1 and word_ack_out=1; word_count_out increments at the exiting edge; last_grant<=ENQ; next state SETTLE.
- DEQ (1 cycle): dequeue_out=1; gap_cnt<=DRAIN_GAP; last_grant<=DEQ; next state SETTLE.
- SETTLE (1 cycle): lets len_in update. consumer_valid_out=1 only if the previous state was DEQ. Next state IDLE. Requests are not sampled in SETTLE.
- Latency: request seen in IDLE at cycle N -> strobe at N+1 -> SETTLE at N+2 -> IDLE at N+3. At most one queue operation per 3 cycles.
- gap_cnt decrements by 1 each cycle while nonzero, in every state except the DEQ load cycle.
- Full: enq_ok=0 and the word stays pending (never dropped); deser_enable_out=0 the cycle after len_in reaches DEPTH.
- Empty: deq_ok=0 and consumer_valid_out stays 0.
- word_ready_in deasserting before ack: the request is simply withdrawn with no side effects.
- len_in > DEPTH is illegal; the block treats it as full.

Test Plan:
- Reset: hold reset=0 for 3 cycles with word_ready_in=1 -> all outputs 0, word_count_out=0. Release -> ENQ pulse exactly 1 cycle after the first IDLE cycle.
- Single word: word_ready_in=1 with len_in=0 -> enqueue_out and word_ack_out high together for 1 cycle; word_count_out 0->1; deserializer drops request after ack; no second pulse.
- Fill to full: 8 back-to-back words with model queue -> enqueues spaced 3 cycles. At len_in=8: full_out=1, deser_enable_out=0, a 9th pending word gets no ack until a dequeue drops len_in to 7.
- Drain with gap: len_in=3, consumer_ready_in=1, DRAIN_GAP=2 -> dequeue_out pulses 3 cycles apart minimum (DEQ, SETTLE+gap). consumer_valid_out high in each SETTLE-after-DEQ; empty_out=1 after the third.
- Arbitration tie: word_ready_in=1, consumer_ready_in=1, len_in=4 continuously -> grants alternate ENQ, DEQ, ENQ, DEQ starting with ENQ; neither side starves.
- Reset mid-op: reset=0 during ENQ cycle -> next cycle enqueue_out=0, word_count_out=0, state IDLE; pending word re-acked once after reset release.
